// File: rtl/request_pending_latch.sv
`default_nettype none
// ============================================================================
// Module      : request_pending_latch
// Description : Sticky per-line request latch in front of the priority
//               encoder. Captures edge- or level-sensitive requests, exposes
//               a masked pending vector, clears bits on a valid/ready
//               acknowledge, counts lost edge events and flags bad acks.
// Revision    : 1.0 - initial release
// ============================================================================
module request_pending_latch #(
    parameter int WIDTH     = 16,
    parameter int ID_WIDTH  = $clog2(WIDTH),
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [WIDTH-1:0]     req_i,
    input  logic [WIDTH-1:0]     edge_mode_i,
    input  logic [WIDTH-1:0]     mask_i,
    output logic [WIDTH-1:0]     pending_o,
    output logic                 any_o,
    input  logic                 ack_valid_i,
    input  logic [ID_WIDTH-1:0]  ack_id_i,
    output logic                 ack_ready_o,
    output logic [CNT_WIDTH-1:0] drop_cnt_o,
    input  logic                 drop_cnt_clr_i,
    output logic                 err_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_READY  = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    state_t               state;
    logic                 ack_ready_q;
    logic [WIDTH-1:0]     req_q;
    logic [WIDTH-1:0]     pend_q;
    logic [CNT_WIDTH-1:0] drop_cnt_q;
    logic                 err_q;

    logic [WIDTH-1:0]     set_vec;
    logic [WIDTH-1:0]     id_onehot;
    logic [WIDTH-1:0]     clear_vec;
    logic                 ack_fire;
    logic                 ack_good;
    logic                 drop_evt;

    // Per-bit set term and one-hot decode of the acknowledged index; an
    // out-of-range index decodes to all zeros and can never be a good ack.
    always_comb begin
        set_vec   = '0;
        id_onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            set_vec[i]   = edge_mode_i[i] ? (req_i[i] & ~req_q[i]) : req_i[i];
            id_onehot[i] = (ack_id_i == ID_WIDTH'(i));
        end
    end

    // Acknowledge qualification, clear vector and drop detection.
    always_comb begin
        ack_fire  = ack_valid_i & ack_ready_q;
        ack_good  = ack_fire & (|(pend_q & id_onehot));
        clear_vec = ack_good ? id_onehot : '0;
        drop_evt  = |(edge_mode_i & set_vec & pend_q & ~clear_vec);
    end

    // Raw pending vector and previous-request history; set beats clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q  <= '0;
            pend_q <= '0;
        end else begin
            req_q  <= req_i;
            pend_q <= (pend_q & ~clear_vec) | set_vec;
        end
    end

    // Acknowledge handshake FSM: one settle cycle after every fire so the
    // encoder sees the cleared bit before the next ack is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_READY;
            ack_ready_q <= 1'b1;
        end else begin
            case (state)
                ST_READY: begin
                    if (ack_fire) begin
                        state       <= ST_SETTLE;
                        ack_ready_q <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    state       <= ST_READY;
                    ack_ready_q <= 1'b1;
                end
                default: begin
                    state       <= ST_READY;
                    ack_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Saturating drop counter; a clear coinciding with a drop restarts at one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_q <= '0;
        end else if (drop_cnt_clr_i) begin
            drop_cnt_q <= drop_evt ? CNT_WIDTH'(1) : '0;
        end else if (drop_evt && (drop_cnt_q != CNT_MAX)) begin
            drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Sticky bad-acknowledge flag, released only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (ack_fire && !ack_good) begin
            err_q <= 1'b1;
        end
    end

    assign pending_o   = pend_q & ~mask_i;
    assign any_o       = |pending_o;
    assign ack_ready_o = ack_ready_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire

// File: doc/request_pending_latch.md
# request_pending_latch

Upstream stage of the priority encoder. Captures per-line requests (edge- or level-sensitive per bit) into a sticky pending vector, applies a mask, and presents the masked vector to the encoder's input. The consumer returns the serviced index over a valid/ready acknowledge channel, which clears that bit. Also counts lost edge events and flags bad acknowledges.

## Interface
Parameters:
- Width, 16, number of request lines
- IDWidth, $clog2(Width), acknowledge index width
- CntWidth, 8, drop counter width

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset; one clock, reset asynchronous and active-low
- req_i  in  Width  request lines, synchronous to clk_i
- edge_mode_i  in  Width  per bit: 1 = rising-edge sensitive, 0 = level sensitive
- mask_i  in  Width  per bit: 1 = hide the bit from pending_o (still latched)
- pending_o  out  Width  masked pending vector; feeds the encoder input
- any_o  out  1  OR-reduction of pending_o
- ack_valid_i  in  1  acknowledge valid
- ack_id_i  in  IDWidth  index being acknowledged
- ack_ready_o  out  1  acknowledge ready
- drop_cnt_o  out  CntWidth  saturating count of lost edge events
- drop_cnt_clr_i  in  1  synchronous clear of drop_cnt_o
- err_o  out  1  sticky bad-acknowledge flag

## Operation
- Registers: req_q (previous req_i), pend_q (raw pending), fsm state, drop counter, err flag.
- Set per bit: edge_mode_i ? (req_i & ~req_q) : req_i.
- Ack fire = ack_valid_i & ack_ready_o. A good ack has ack_id_i < Width and pend_q[ack_id_i] = 1; it clears that bit.
- Bad ack (id ≥ Width, or bit not pending) changes no pending bit and sets err_o. err_o is cleared only by reset.
- pend_q next = (pend_q & ~clear) | set.
  - Set wins over a simultaneous clear on the same bit.
  - A level-mode bit therefore remains pending while req_i stays high.
- Drop event:
  - Occurs in a cycle where some edge-mode bit has set = 1, pend_q = 1, and no good ack clears that bit in that cycle.
  - The counter increments by 1 per cycle with at least one drop, regardless of how many bits drop.
  - The counter saturates at all-ones.
  - Level-mode bits never count as drops.
- drop_cnt_clr_i: the counter loads 0, or loads 1 if a drop occurs in the same cycle.
- pending_o = pend_q & ~mask_i, combinational. Masking never clears pend_q; unmasking immediately exposes a latched bit.
- FSM, two states:
  - READY: ack_ready_o = 1. Ack fire (good or bad) → SETTLE.
  - SETTLE: ack_ready_o = 0. Unconditionally → READY.
  - SETTLE guarantees the downstream encoder output reflects the cleared bit before the next ack.
- Reset values: pend_q = 0, req_q = 0, state READY, drop_cnt_o = 0, err_o = 0. Hence pending_o = 0, any_o = 0, ack_ready_o = 1.
- Reset mid-operation clears all state asynchronously. An edge-mode req_i held high across reset release is seen as a rising edge on the first clock.

## Timing
- req_i edge/level at clock edge t → pending_o bit high after edge t (visible cycle t+1). Latency 1.
- mask_i → pending_o / any_o: combinational, 0 cycles.
- Ack fire at edge t:
  - bit cleared and ack_ready_o low during cycle t+1
  - ack_ready_o high again in cycle t+2
  - maximum ack rate is one per 2 cycles
- ack_valid_i may stay asserted through SETTLE; no fire occurs there, so the held ack fires in the next READY cycle.
- drop_cnt_o and err_o update at the edge of the causing cycle (visible the next cycle).
- No combinational path from ack_valid_i to ack_ready_o.

## Test plan
- Reset: with rst_ni low, pending_o = 0, any_o = 0, ack_ready_o = 1, drop_cnt_o = 0, err_o = 0. Release with req_i[3] = 1 (edge mode) → pending_o = 0x0008 one cycle later.
- Edge capture and ack:
  - Pulse req_i[5] (edge) → pending_o = 0x0020.
  - Ack id 5 → pending_o = 0x0000 next cycle; ack_ready_o low for exactly one cycle.
- Level priority over clear: req_i[2] held high (level), ack id 2 → pending_o bit 2 stays 1 and err_o stays 0.
- Drops:
  - Bit 7 pending, three further rising edges on req_i[7] with no ack → drop_cnt_o = 3.
  - Drive 300 drop cycles → drop_cnt_o = 255.
  - Pulse drop_cnt_clr_i → 0.
- Mask: latch bit 9 with mask_i[9] = 1 → pending_o = 0, any_o = 0. Clear mask_i[9] → pending_o = 0x0200 the same cycle.
- Bad ack and back-to-back acks:
  - Ack id 4 with bit 4 not pending → err_o = 1, pending unchanged.
  - With ack_valid_i held for two acks, the fires are 2 cycles apart.
